psum_serializer: RTL and testbench

Transmit-side partner of the partial-sum accumulator. Accepts one complete group of GROUP partial sums in parallel from the PE column (valid/ready), buffers up to DEPTH groups, and replays them one word per cycle on the accumulator's `en`/`psum_in` stream. `en` is held high for the whole group and back-to-back groups, so the accumulator's element counter never desynchronises. Sits between the PE array row outputs and the psum accumulator.

---
 rtl/psum_pkg.sv | 17 +
 rtl/psum_group_fifo.sv | 66 ++++++
 rtl/psum_serializer.sv | 131 +++++++++++++
 tb/tb_psum_serializer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum serializer and its accumulator partner.
package psum_pkg;

  localparam int PSUM_DATA_W = 16;
  localparam int PSUM_GROUP  = 3;

  // Emit-side state encoding, kept as plain constants so older tools accept it.
  typedef logic [0:0] emit_state_t;
  localparam emit_state_t ST_IDLE = 1'b0;
  localparam emit_state_t ST_EMIT = 1'b1;

  // Width of an element index; never narrower than one bit.
  function automatic int idx_width(input int group);
    return (group > 1) ? $clog2(group) : 1;
  endfunction

endpackage

// File: rtl/psum_group_fifo.sv
// Group buffer: DEPTH slots of one whole group each, with head and next-head views.
module psum_group_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] head_next_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             more_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Slot storage carries no reset: stale contents are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next head is needed when the current head pops and emission continues without a bubble.
  assign rd_ptr_nxt  = rd_ptr_q + PTR_W'(1);
  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[rd_ptr_nxt];
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign more_o      = (count_q > CNT_W'(1));

endmodule

// File: rtl/psum_serializer.sv
// Buffers parallel partial-sum groups and replays them one word per cycle to the accumulator.
module psum_serializer
  import psum_pkg::*;
#(
  parameter int DATA_W = PSUM_DATA_W,
  parameter int GROUP  = PSUM_GROUP,
  parameter int DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [GROUP*DATA_W-1:0]       in_psum_vec,
  output logic [DATA_W-1:0]             psum_out,
  output logic                          psum_en,
  output logic                          psum_last,
  output logic [idx_width(GROUP)-1:0]   psum_idx,
  output logic [15:0]                   groups_sent
);

  localparam int                IDX_W    = idx_width(GROUP);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(GROUP - 1);

  emit_state_t              state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]        out_q, out_d;
  logic                     en_q, en_d;
  logic                     last_q, last_d;
  logic [15:0]              gs_q, gs_d;

  logic                     push_w, pop_w;
  logic [GROUP*DATA_W-1:0]  head_w, head_next_w, grp_w;
  logic                     full_w, empty_w, more_w;
  logic [DATA_W-1:0]        elem_w [GROUP];

  psum_group_fifo #(
    .WIDTH (GROUP * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_w),
    .pop_i       (pop_w),
    .wr_data_i   (in_psum_vec),
    .head_o      (head_w),
    .head_next_o (head_next_w),
    .full_o      (full_w),
    .empty_o     (empty_w),
    .more_o      (more_w)
  );

  // Readiness depends only on registered occupancy, never on a same-cycle pop.
  assign in_ready = !rst && !full_w;
  assign push_w   = in_valid && in_ready;
  assign pop_w    = (state_q == ST_EMIT) && (idx_q == LAST_IDX);

  // When the head pops and emission continues, the next word comes from the following slot.
  assign grp_w = pop_w ? head_next_w : head_w;

  generate
    for (genvar gi = 0; gi < GROUP; gi++) begin : g_elem
      assign elem_w[gi] = grp_w[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Emit FSM: leave IDLE when the buffer holds a group, chain groups while more remain.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gs_d    = gs_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (!empty_w) begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        if (pop_w) begin
          gs_d  = gs_q + 16'd1;
          idx_d = '0;
          if (!more_w) begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    endcase
  end

  // Output register inputs follow the next state so every port is driven from a flop.
  always_comb begin
    en_d   = (state_d == ST_EMIT);
    last_d = en_d && (idx_d == LAST_IDX);
    out_d  = '0;
    if (en_d) begin
      for (int k = 0; k < GROUP; k++) begin
        if (idx_d == IDX_W'(k)) begin
          out_d = elem_w[k];
        end
      end
    end
  end

  // State and output registers; reset abandons any partially sent group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
      gs_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      en_q    <= en_d;
      last_q  <= last_d;
      gs_q    <= gs_d;
    end
  end

  assign psum_out    = out_q;
  assign psum_en     = en_q;
  assign psum_last   = last_q;
  assign psum_idx    = idx_q;
  assign groups_sent = gs_q;

endmodule

// File: tb/tb_psum_serializer.sv
// Bench for psum_serializer: directed cycle table, reset corner, random traffic, counter wrap.
module tb_psum_serializer;
  import psum_pkg::*;

  localparam int DW = 16;
  localparam int GR = 3;
  localparam int DP = 2;
  localparam int RN = 400;
  localparam int RA = RN + 40;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [GR*DW-1:0] in_psum_vec = '0;
  logic           in_ready;
  logic [DW-1:0]  psum_out;
  logic           psum_en;
  logic           psum_last;
  logic [1:0]     psum_idx;
  logic [15:0]    groups_sent;

  logic           w_valid = 1'b0;
  logic [DW-1:0]  w_vec = '0;
  logic           w_ready;
  logic [DW-1:0]  w_out;
  logic           w_en;
  logic           w_last;
  logic [0:0]     w_idx;
  logic [15:0]    w_gs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  psum_serializer #(.DATA_W(DW), .GROUP(GR), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_psum_vec(in_psum_vec), .psum_out(psum_out), .psum_en(psum_en),
    .psum_last(psum_last), .psum_idx(psum_idx), .groups_sent(groups_sent)
  );

  psum_serializer #(.DATA_W(DW), .GROUP(1), .DEPTH(4)) w_dut (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_ready),
    .in_psum_vec(w_vec), .psum_out(w_out), .psum_en(w_en),
    .psum_last(w_last), .psum_idx(w_idx), .groups_sent(w_gs)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic r, input logic en, input logic [DW-1:0] o,
                         input logic l, input logic [1:0] i, input logic [15:0] g);
    chk({tag, ".ready"}, 32'(in_ready), 32'(r));
    chk({tag, ".en"},    32'(psum_en), 32'(en));
    chk({tag, ".out"},   32'(psum_out), 32'(o));
    chk({tag, ".last"},  32'(psum_last), 32'(l));
    chk({tag, ".idx"},   32'(psum_idx), 32'(i));
    chk({tag, ".gs"},    32'(groups_sent), 32'(g));
  endtask

  function automatic logic [GR*DW-1:0] pack3(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                             input logic [DW-1:0] d2);
    return {d2, d1, d0};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // One row per cycle: inputs driven for the next edge, outputs expected in this cycle.
  typedef struct {
    logic          v;
    logic [DW-1:0] d0, d1, d2;
    logic          r, en;
    logic [DW-1:0] o;
    logic          l;
    logic [1:0]    i;
    logic [15:0]   g;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW-1:0] d2, input logic r, input logic en,
                              input logic [DW-1:0] o, input logic l, input logic [1:0] i,
                              input logic [15:0] g);
    vec_t t;
    t.v = v; t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.r = r; t.en = en; t.o = o; t.l = l; t.i = i; t.g = g;
    return t;
  endfunction

  vec_t tbl [32];

  // Random-phase expectations per cycle, built from the scheduling rule of the stream.
  logic          xe [RA];
  logic [DW-1:0] xo [RA];
  logic          xl [RA];
  logic [1:0]    xi [RA];
  int            popat [RA];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, pops, last_end, start, cnt, rate, wacc, guard, target;
    logic exp_r, hold;
    logic [GR*DW-1:0] vec;
    logic [DW-1:0] w0, w1, w2;

    // Group A, B, C back to back (C refused twice), D and E with a gap, F then G pushed on F's pop edge.
    tbl[0]  = mk(1, 16'h0001, 16'h0002, 16'h0003, 1, 0, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(1, 16'h0004, 16'h0005, 16'h0006, 1, 0, 16'h0000, 0, 0, 0);
    tbl[2]  = mk(1, 16'hFFFF, 16'h8000, 16'h0000, 0, 1, 16'h0001, 0, 0, 0);
    tbl[3]  = mk(1, 16'hFFFF, 16'h8000, 16'h0000, 0, 1, 16'h0002, 0, 1, 0);
    tbl[4]  = mk(1, 16'hFFFF, 16'h8000, 16'h0000, 0, 1, 16'h0003, 1, 2, 0);
    tbl[5]  = mk(1, 16'hFFFF, 16'h8000, 16'h0000, 1, 1, 16'h0004, 0, 0, 1);
    tbl[6]  = mk(0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0005, 0, 1, 1);
    tbl[7]  = mk(0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0006, 1, 2, 1);
    tbl[8]  = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'hFFFF, 0, 0, 2);
    tbl[9]  = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h8000, 0, 1, 2);
    tbl[10] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0000, 1, 2, 2);
    tbl[11] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 3);
    tbl[12] = mk(1, 16'h000A, 16'h000B, 16'h000C, 1, 0, 16'h0000, 0, 0, 3);
    tbl[13] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 3);
    tbl[14] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h000A, 0, 0, 3);
    tbl[15] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h000B, 0, 1, 3);
    tbl[16] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h000C, 1, 2, 3);
    tbl[17] = mk(1, 16'h0010, 16'h0020, 16'h0030, 1, 0, 16'h0000, 0, 0, 4);
    tbl[18] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 4);
    tbl[19] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0010, 0, 0, 4);
    tbl[20] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0020, 0, 1, 4);
    tbl[21] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0030, 1, 2, 4);
    tbl[22] = mk(1, 16'h1111, 16'h2222, 16'h3333, 1, 0, 16'h0000, 0, 0, 5);
    tbl[23] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 5);
    tbl[24] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h1111, 0, 0, 5);
    tbl[25] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h2222, 0, 1, 5);
    tbl[26] = mk(1, 16'h4444, 16'h5555, 16'h6666, 1, 1, 16'h3333, 1, 2, 5);
    tbl[27] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 6);
    tbl[28] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h4444, 0, 0, 6);
    tbl[29] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h5555, 0, 1, 6);
    tbl[30] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h6666, 1, 2, 6);
    tbl[31] = mk(0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 7);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000);
    rst = 1'b0;

    // Directed cycle table.
    for (int n = 0; n < 32; n++) begin
      #1;
      chk_out($sformatf("tbl%0d", n), tbl[n].r, tbl[n].en, tbl[n].o, tbl[n].l, tbl[n].i, tbl[n].g);
      in_valid    = tbl[n].v;
      in_psum_vec = pack3(tbl[n].d0, tbl[n].d1, tbl[n].d2);
      if (tbl[n].v && tbl[n].r)
        $display("tbl row %0d: offer group %h %h %h (accepted)", n, tbl[n].d0, tbl[n].d1, tbl[n].d2);
      else if (tbl[n].v)
        $display("tbl row %0d: offer group %h %h %h (held)", n, tbl[n].d0, tbl[n].d1, tbl[n].d2);
      @(negedge clk);
    end

    // Reset while the first group is on element 1 and a second group waits in the buffer.
    in_valid = 1'b1;
    in_psum_vec = pack3(16'h0101, 16'h0202, 16'h0303);
    @(negedge clk);
    in_psum_vec = pack3(16'h0404, 16'h0505, 16'h0606);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid.pre_idx", 32'(psum_idx), 32'd1);
    chk("rstmid.pre_out", 32'(psum_out), 32'h0202);
    rst = 1'b1;
    #1;
    chk("rstmid.ready_in_rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk_out("rstmid.after", 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000);
    rst = 1'b0;
    #1;
    chk("rstmid.ready_release", 32'(in_ready), 32'd1);
    $display("reset applied mid-group; buffered groups discarded");
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rstmid.quiet%0d", n), 32'({psum_en, groups_sent}), 32'd0);
    end
    @(negedge clk);

    // Random traffic against a schedule model: a group accepted at edge a starts at
    // max(a+1, end_of_previous_group+1) and pops at the edge after its last element.
    for (int k = 0; k < RA; k++) begin
      xe[k] = 1'b0; xo[k] = '0; xl[k] = 1'b0; xi[k] = '0; popat[k] = 0;
    end
    acc = 0; pops = 0; last_end = -100; hold = 1'b0; vec = '0;
    for (int c = 0; c < RN + 20; c++) begin
      #1;
      pops += popat[c];
      cnt = acc - pops;
      exp_r = (cnt != DP);
      chk_out($sformatf("rnd%0d", c), exp_r, xe[c], xo[c], xl[c], xi[c], 16'(pops));
      rate = (c < RN / 2) ? 75 : 30;
      if (c >= RN) begin
        in_valid = 1'b0;
        hold = 1'b0;
      end else if (!hold) begin
        in_valid = ($urandom_range(0, 99) < rate);
        w0 = rand_word(); w1 = rand_word(); w2 = rand_word();
        vec = pack3(w0, w1, w2);
      end
      in_psum_vec = vec;
      if (in_valid && exp_r) begin
        start = (c + 2 > last_end + 1) ? c + 2 : last_end + 1;
        for (int e = 0; e < GR; e++) begin
          xe[start + e] = 1'b1;
          xo[start + e] = vec[e*DW +: DW];
          xl[start + e] = (e == GR - 1);
          xi[start + e] = 2'(e);
        end
        last_end = start + GR - 1;
        popat[last_end + 1]++;
        acc++;
        hold = 1'b0;
        $display("rnd cycle %0d: accept group %h, expected start cycle %0d", c, vec, start);
      end else begin
        hold = in_valid;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Counter wrap on a single-element instance: 65535 groups, then one more.
    wacc = 0;
    for (int t = 0; t < 2; t++) begin
      target = (t == 0) ? 65535 : 65536;
      guard = 0;
      while (wacc < target && guard < 80000) begin
        w_valid = 1'b1;
        w_vec = 16'($urandom);
        #1;
        if (w_ready) wacc++;
        @(negedge clk);
        guard++;
      end
      w_valid = 1'b0;
      chk($sformatf("wrap%0d.accepts", t), 32'(wacc), 32'(target));
      repeat (10) @(negedge clk);
      #1;
      chk($sformatf("wrap%0d.groups_sent", t), 32'(w_gs), (t == 0) ? 32'h0000FFFF : 32'h00000000);
      chk($sformatf("wrap%0d.idle", t), 32'(w_en), 32'd0);
      $display("wrap phase %0d: %0d groups pushed, groups_sent=%h", t, wacc, w_gs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
